demux_stream4: RTL
==================

# demux_stream4

Registered 1-to-4 stream demultiplexer with valid/ready handshakes, the inverse of the 4:1 select mux. One input stream of WIDTH-bit beats is routed to one of four output channels by a 2-bit select `{s1,s2}`. The select is locked for the duration of a burst delimited by `in_last`. Each channel has a one-entry output register and an 8-bit accepted-beat counter. It sits on the fan-out side of the datapath, downstream of a single producer, and feeds four independent consumers.

## Interface
- WIDTH, 8, data width of one beat
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- in_valid  input  1  input beat present
- in_ready  output  1  block accepts the input beat this cycle
- in_data  input  WIDTH  input beat payload
- in_last  input  1  beat is the final beat of a burst
- s1  input  1  select MSB
- s2  input  1  select LSB; channel index = {s1,s2}
- out_valid  output  4  per-channel beat present; bit n = channel n
- out_ready  input  4  per-channel consumer accepts
- out_data  output  4*WIDTH  channel n payload at [n*WIDTH +: WIDTH]
- out_last  output  4  per-channel last flag
- beat_cnt  output  32  channel n accepted-beat count at [n*8 +: 8]

## Operation
- Handshakes: input accept = in_valid & in_ready. Channel n drain = out_valid[n] & out_ready[n].
- Active channel `ch`:
  - IDLE: ch = {s1,s2}.
  - BURST: ch = locked_sel.
- in_ready = ~out_valid[ch] | out_ready[ch]. This is combinational from out_ready, with no bubble when a channel is drained and refilled in the same cycle.
- FSM states: IDLE, BURST.
  - IDLE → BURST on accept with in_last=0; locked_sel <= {s1,s2}.
  - BURST → IDLE on accept with in_last=1.
  - Accept with in_last=1 in IDLE (single-beat burst) stays in IDLE.
  - No accept: state held.
  - s1/s2 changes during BURST are ignored.
- On accept: out_data[ch] <= in_data, out_last[ch] <= in_last, out_valid[ch] <= 1, beat_cnt[ch] <= beat_cnt[ch]+1.
- On drain of channel n with no simultaneous load: out_valid[n] <= 0. out_data and out_last hold their last value.
- Simultaneous drain and load on the same channel: out_valid stays 1 and the register takes the new beat.
- Non-selected channels drain independently of the input side. A stalled channel never blocks draining of the others.
- beat_cnt is 8-bit per channel and wraps 255 → 0 without any flag.
- in_data, in_last, s1, s2 are don't-care when in_valid=0. Selection never changes out_* registers without an accept.

## Timing
- Reset (rst_n=0 at a clk edge): state=IDLE, locked_sel=0, out_valid=0, out_data=0, out_last=0, beat_cnt=0.
- During reset, in_ready is forced 0.
- Reset mid-burst discards the burst and any beats held in the output registers. The first beat after reset is routed by {s1,s2}.
- Latency: a beat accepted at edge k shows out_valid[ch]=1 with its data from edge k until drained, i.e. one cycle from input to output.
- Throughput: 1 beat/cycle while the target consumer holds out_ready=1.
- in_ready may fall only because out_valid[ch] is set and out_ready[ch] is low. It has no other stall source.
- beat_cnt updates at the same edge as the output register load.

## Test plan
- Reset then single beats:
  - Stimulus: rst_n=0 for 2 cycles, all out_ready=1. Send 0x11 with sel=0, 0x22 with sel=1, 0x33 with sel=2, 0x44 with sel=3, each with last=1.
  - Required response: each value appears on its channel one cycle later, one beat per cycle. beat_cnt = 0x01010101.
- Burst lock:
  - Stimulus: sel=2, send 4 beats 0xA0..0xA3 with last only on 0xA3. Toggle s1/s2 every cycle during the burst.
  - Required response: all 4 beats exit channel 2 with out_last only on 0xA3. beat_cnt[2]=4. The next beat is routed by the current {s1,s2}.
- Backpressure:
  - Stimulus: out_ready[1]=0, two beats to channel 1.
  - Required response: first beat held, in_ready=0 on the second beat. Raise out_ready[1]: the first beat drains, the second is loaded the same cycle, and there is no beat loss or duplication.
- Independent drain:
  - Stimulus: channel 0 stalled and full. Beats are sent to channel 3 with out_ready[3]=1.
  - Required response: channel 3 flows at 1 beat/cycle. Channel 0 holds its data unchanged.
- Counter wrap:
  - Stimulus: 257 beats to channel 0.
  - Required response: beat_cnt[7:0]=1 and the other counts are 0.
- Reset mid-burst:
  - Stimulus: 2 beats of an unfinished burst on channel 1, then rst_n=0 for 1 cycle.
  - Required response: all outputs are 0. The next beat with sel=3 exits on channel 3.

Source files
------------

// File: rtl/demux_stream4.sv
// Registered 1-to-4 stream demux; burst-locked select, one-entry register and 8-bit beat counter per channel.
// Latency: 1 cycle input->output. Backpressure: in_ready follows only the active channel's register (full and not draining).
module demux_stream4 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    input  logic               s1,
    input  logic               s2,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_last,
    output logic [31:0]        beat_cnt
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_q;
    logic [1:0]       locked_sel_q;
    logic [3:0]       valid_q;
    logic [3:0]       last_q;
    logic [WIDTH-1:0] data_q [4];
    logic [7:0]       cnt_q  [4];

    logic [1:0] ch_d;
    logic       accept_d;
    logic [3:0] load_d;

    // Select is sampled live only between bursts; mid-burst the locked channel wins.
    assign ch_d     = (state_q == BURST) ? locked_sel_q : {s1, s2};
    assign in_ready = rst_n & (~valid_q[ch_d] | out_ready[ch_d]);
    assign accept_d = in_valid & in_ready;
    assign load_d   = accept_d ? (4'b0001 << ch_d) : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            locked_sel_q <= 2'd0;
            valid_q      <= 4'd0;
            last_q       <= 4'd0;
            for (int n = 0; n < 4; n++) begin
                data_q[n] <= '0;
                cnt_q[n]  <= 8'd0;
            end
        end else begin
            if (accept_d) begin
                case (state_q)
                    IDLE: begin
                        if (!in_last) begin
                            state_q      <= BURST;
                            locked_sel_q <= {s1, s2};
                        end
                    end
                    BURST: begin
                        if (in_last) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
            // A load takes priority over a drain, so drain+load keeps valid high.
            for (int n = 0; n < 4; n++) begin
                if (load_d[n]) begin
                    valid_q[n] <= 1'b1;
                    data_q[n]  <= in_data;
                    last_q[n]  <= in_last;
                    cnt_q[n]   <= cnt_q[n] + 8'd1;
                end else if (valid_q[n] && out_ready[n]) begin
                    valid_q[n] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign out_last  = last_q;

    for (genvar g = 0; g < 4; g++) begin : g_out
        assign out_data[g*WIDTH +: WIDTH] = data_q[g];
        assign beat_cnt[g*8 +: 8]         = cnt_q[g];
    end

endmodule
